// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, the
// sequential increment constants and the redirect alignment rule.
package pc_sequencer_pkg;

    // State encoding is visible on the state output: BOOT=0, RUN=1, HALT=2.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Sequential increments for 16-bit and 32-bit instructions.
    localparam logic [2:0] PC_INC2 = 3'd2;
    localparam logic [2:0] PC_INC4 = 3'd4;

    // A target is misaligned if it is odd, or if it is not word aligned
    // while 16-bit instructions are not supported.
    function automatic logic target_misaligned(input logic bit1,
                                               input logic bit0,
                                               input logic compressed);
        return bit0 | (~compressed & bit1);
    endfunction

endpackage

// File: rtl/pc_align_check.sv
// Redirect alignment checker.
// Ports:
//   target_i     - low two bits of the redirect target
//   misaligned_o - high when the target cannot be fetched
// Only bits [1:0] decide alignment, so only they are brought in.
module pc_align_check
    import pc_sequencer_pkg::*;
#(
    parameter bit COMPRESSED = 1'b0
) (
    input  logic [1:0] target_i,
    output logic       misaligned_o
);

    assign misaligned_o = target_misaligned(target_i[1], target_i[0], COMPRESSED);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a BOOT/RUN/HALT state machine.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   stall               - hold the PC in RUN
//   inst_compressed     - current instruction is 16-bit (COMPRESSED=1 only)
//   redirect_valid/_target - branch or jump request
//   trap, mret          - exception entry / return to epc
//   halt_req, resume    - enter / leave HALT
//   pc, epc             - registered current PC and exception PC
//   pc_next_seq         - combinational sequential successor of pc
//   pc_valid            - registered, high only in RUN
//   misalign_err        - registered one-cycle pulse after a misaligned redirect
//   state               - registered FSM state (BOOT=0, RUN=1, HALT=2)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
    parameter bit              COMPRESSED   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            inst_compressed,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            mret,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misalign_err,
    output logic [1:0]      state
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic            pc_valid_q;
    logic            misalign_q;
    logic [XLEN-1:0] inc_s;
    logic            misaligned_s;

    pc_align_check #(
        .COMPRESSED (COMPRESSED)
    ) u_align (
        .target_i     (redirect_target[1:0]),
        .misaligned_o (misaligned_s)
    );

    // Select the sequential increment; inst_compressed only matters when
    // 16-bit instructions are enabled.
    always_comb begin
        inc_s = {{(XLEN-3){1'b0}}, PC_INC4};
        if ((COMPRESSED == 1'b1) && inst_compressed) begin
            inc_s = {{(XLEN-3){1'b0}}, PC_INC2};
        end else begin
            inc_s = {{(XLEN-3){1'b0}}, PC_INC4};
        end
    end

    // The sum is truncated to XLEN bits so the PC wraps with no carry out.
    assign pc_next_seq = pc_q + inc_s;

    // State machine and all architectural PC state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epc_q      <= {XLEN{1'b0}};
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    // Inputs are ignored; pc stays at RESET_VECTOR.
                    state_q    <= ST_RUN;
                    pc_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (trap) begin
                        epc_q <= pc_q;
                        pc_q  <= TRAP_VECTOR;
                    end else if (mret) begin
                        pc_q <= epc_q;
                    end else if (redirect_valid) begin
                        if (misaligned_s) begin
                            epc_q      <= pc_q;
                            pc_q       <= TRAP_VECTOR;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q <= redirect_target;
                        end
                    end else if (halt_req) begin
                        state_q    <= ST_HALT;
                        pc_valid_q <= 1'b0;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else begin
                        pc_q <= pc_next_seq;
                    end
                end
                ST_HALT: begin
                    // Only resume is honoured here; pc is frozen.
                    if (resume) begin
                        state_q    <= ST_RUN;
                        pc_valid_q <= 1'b1;
                    end else begin
                        state_q    <= ST_HALT;
                        pc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    pc_q       <= RESET_VECTOR;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign pc_valid     = pc_valid_q;
    assign misalign_err = misalign_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. Two instances share the stimulus:
// dut_a (RESET_VECTOR='h80, word aligned) and dut_c (RESET_VECTOR=0,
// 16-bit instructions enabled). Expected values are pushed to a scoreboard
// queue as each stimulus cycle is driven and popped after the clock edge.
module tb_pc_sequencer;

    // Control bit positions: {stall, ic, redirect, trap, mret, halt, resume}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1000000;
    localparam logic [6:0] C_IC    = 7'b0100000;
    localparam logic [6:0] C_RV    = 7'b0010000;
    localparam logic [6:0] C_TRAP  = 7'b0001000;
    localparam logic [6:0] C_MRET  = 7'b0000100;
    localparam logic [6:0] C_HALT  = 7'b0000010;
    localparam logic [6:0] C_RES   = 7'b0000001;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] tgt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        err;
        logic [1:0]  st;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, inst_compressed = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap = 1'b0, mret = 1'b0, halt_req = 1'b0, resume = 1'b0;

    logic [31:0] pc_a, nxt_a, epc_a, pc_c, nxt_c, epc_c;
    logic        valid_a, err_a, valid_c, err_c;
    logic [1:0]  st_a, st_c;

    int   total_cnt = 0;
    int   pass_cnt  = 0;
    exp_t sb [$];

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .COMPRESSED(1'b0)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .inst_compressed(inst_compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .mret(mret), .halt_req(halt_req), .resume(resume),
        .pc(pc_a), .pc_next_seq(nxt_a), .pc_valid(valid_a), .epc(epc_a),
        .misalign_err(err_a), .state(st_a)
    );

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .COMPRESSED(1'b1)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .inst_compressed(inst_compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap(trap), .mret(mret), .halt_req(halt_req), .resume(resume),
        .pc(pc_c), .pc_next_seq(nxt_c), .pc_valid(valid_c), .epc(epc_c),
        .misalign_err(err_c), .state(st_c)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk_s(input logic [6:0] ctl, input logic [31:0] tgt);
        mk_s.ctl = ctl;
        mk_s.tgt = tgt;
    endfunction

    function automatic exp_t mk_e(input logic [31:0] p, input logic [31:0] e,
                                  input logic r, input logic [1:0] s, input logic v);
        mk_e.pc = p; mk_e.epc = e; mk_e.err = r; mk_e.st = s; mk_e.valid = v;
    endfunction

    function automatic exp_t obs(input bit use_c);
        if (use_c) obs = mk_e(pc_c, epc_c, err_c, st_c, valid_c);
        else       obs = mk_e(pc_a, epc_a, err_a, st_a, valid_a);
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("pc=%h epc=%h err=%b st=%0d valid=%b", x.pc, x.epc, x.err, x.st, x.valid);
    endfunction

    task automatic apply(input stim_t s);
        {stall, inst_compressed, redirect_valid, trap, mret, halt_req, resume} = s.ctl;
        redirect_target = s.tgt;
    endtask

    // Reset values, one BOOT cycle ignoring inputs, then sequential fetch.
    task automatic test_reset();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = obs(1'b0); want = mk_e(32'h80, 32'h0, 1'b0, 2'd0, 1'b0);
        total_cnt++;
        if (got !== want) $display("FAIL reset_state: got %s, want %s", fmt(got), fmt(want));
        else pass_cnt++;
        reset = 1'b0;
        #1;
        got = obs(1'b0); want = mk_e(32'h80, 32'h0, 1'b0, 2'd0, 1'b0);
        total_cnt++;
        if (got !== want) $display("FAIL boot_cycle: got %s, want %s", fmt(got), fmt(want));
        else pass_cnt++;
        sq.push_back(mk_s(C_TRAP | C_RV | C_HALT, 32'h44)); eq.push_back(mk_e(32'h80, 32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));                   eq.push_back(mk_e(32'h84, 32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));                   eq.push_back(mk_e(32'h88, 32'h0, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL boot_run[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // Stall holds the PC; redirect takes effect the next cycle.
    task automatic test_stall_redirect();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        sq.push_back(mk_s(C_RV, 32'h10));    eq.push_back(mk_e(32'h10, 32'h0, 1'b0, 2'd1, 1'b1));
        for (int k = 0; k < 3; k++) begin
            sq.push_back(mk_s(C_STALL, 32'h0)); eq.push_back(mk_e(32'h10, 32'h0, 1'b0, 2'd1, 1'b1));
        end
        sq.push_back(mk_s(C_RV, 32'h40));    eq.push_back(mk_e(32'h40, 32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));   eq.push_back(mk_e(32'h44, 32'h0, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL stall_redirect[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
        apply(mk_s(C_STALL | C_IC, 32'h0));
        #1;
        total_cnt++;
        if (nxt_a !== 32'h48) $display("FAIL next_seq_stall: got %h, want %h", nxt_a, 32'h48);
        else pass_cnt++;
    endtask

    // Misaligned redirects trap with a one-cycle error pulse; mret returns.
    task automatic test_misalign();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        sq.push_back(mk_s(C_RV, 32'h20));   eq.push_back(mk_e(32'h20,  32'h0,  1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV, 32'h42));   eq.push_back(mk_e(32'h100, 32'h20, 1'b1, 2'd1, 1'b1));
        sq.push_back(mk_s(C_MRET, 32'h0));  eq.push_back(mk_e(32'h20,  32'h20, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV, 32'h23));   eq.push_back(mk_e(32'h100, 32'h20, 1'b1, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));  eq.push_back(mk_e(32'h104, 32'h20, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_MRET, 32'h0));  eq.push_back(mk_e(32'h20,  32'h20, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL misalign[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // Simultaneous requests resolve as trap > mret > redirect > halt > stall.
    task automatic test_priority();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        sq.push_back(mk_s(C_RV, 32'h30));                                 eq.push_back(mk_e(32'h30,  32'h20, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_TRAP | C_RV | C_STALL | C_MRET | C_HALT, 32'h40)); eq.push_back(mk_e(32'h100, 32'h30, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_MRET | C_RV | C_HALT, 32'h60));               eq.push_back(mk_e(32'h30,  32'h30, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV | C_HALT | C_STALL, 32'h60));              eq.push_back(mk_e(32'h60,  32'h30, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_HALT | C_STALL, 32'h0));                      eq.push_back(mk_e(32'h60,  32'h30, 1'b0, 2'd2, 1'b0));
        sq.push_back(mk_s(C_RES, 32'h0));                                 eq.push_back(mk_e(32'h60,  32'h30, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV | C_HALT, 32'h62));                        eq.push_back(mk_e(32'h100, 32'h60, 1'b1, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));                                eq.push_back(mk_e(32'h104, 32'h60, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL priority[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // HALT freezes pc and ignores everything except resume.
    task automatic test_halt();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        sq.push_back(mk_s(C_RV, 32'h50));                             eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_HALT, 32'h0));                            eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd2, 1'b0));
        sq.push_back(mk_s(C_TRAP | C_RV | C_STALL, 32'h70));          eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd2, 1'b0));
        sq.push_back(mk_s(C_MRET | C_RV, 32'h71));                    eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd2, 1'b0));
        sq.push_back(mk_s(C_RV | C_HALT, 32'h70));                    eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd2, 1'b0));
        sq.push_back(mk_s(C_IDLE, 32'h0));                            eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd2, 1'b0));
        sq.push_back(mk_s(C_RES, 32'h0));                             eq.push_back(mk_e(32'h50, 32'h60, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));                            eq.push_back(mk_e(32'h54, 32'h60, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_HALT, 32'h0));                            eq.push_back(mk_e(32'h54, 32'h60, 1'b0, 2'd2, 1'b0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL halt[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // Reset while halted with a trap pending: immediate BOOT, nothing survives.
    task automatic test_reset_in_halt();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        apply(mk_s(C_TRAP | C_RV, 32'h200));
        reset = 1'b1;
        #1;
        got = obs(1'b0); want = mk_e(32'h80, 32'h0, 1'b0, 2'd0, 1'b0);
        total_cnt++;
        if (got !== want) $display("FAIL async_reset: got %s, want %s", fmt(got), fmt(want));
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        sq.push_back(mk_s(C_TRAP | C_RV, 32'h200)); eq.push_back(mk_e(32'h80, 32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));          eq.push_back(mk_e(32'h84, 32'h0, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL reset_in_halt[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // PC wraps to zero; inst_compressed has no effect when word aligned.
    task automatic test_wrap();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        sq.push_back(mk_s(C_RV, 32'hFFFF_FFFC)); eq.push_back(mk_e(32'hFFFF_FFFC, 32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));       eq.push_back(mk_e(32'h0,         32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IC, 32'h0));         eq.push_back(mk_e(32'h4,         32'h0, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b0); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL wrap[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    // 16-bit instruction support on dut_c.
    task automatic test_compressed();
        stim_t sq [$];
        exp_t  eq [$];
        exp_t  got, want;
        apply(mk_s(C_IDLE, 32'h0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sq.push_back(mk_s(C_IDLE, 32'h0));       eq.push_back(mk_e(32'h0,         32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IC, 32'h0));         eq.push_back(mk_e(32'h2,         32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IC, 32'h0));         eq.push_back(mk_e(32'h4,         32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV, 32'h6));         eq.push_back(mk_e(32'h6,         32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IDLE, 32'h0));       eq.push_back(mk_e(32'hA,         32'h0, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV, 32'h7));         eq.push_back(mk_e(32'h100,       32'hA, 1'b1, 2'd1, 1'b1));
        sq.push_back(mk_s(C_MRET, 32'h0));       eq.push_back(mk_e(32'hA,         32'hA, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_RV, 32'hFFFF_FFFE)); eq.push_back(mk_e(32'hFFFF_FFFE, 32'hA, 1'b0, 2'd1, 1'b1));
        sq.push_back(mk_s(C_IC, 32'h0));         eq.push_back(mk_e(32'h0,         32'hA, 1'b0, 2'd1, 1'b1));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i]);
            sb.push_back(eq[i]);
            @(posedge clk); #1;
            got = obs(1'b1); want = sb.pop_front();
            total_cnt++;
            if (got !== want) $display("FAIL compressed[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            else pass_cnt++;
            @(negedge clk);
        end
        apply(mk_s(C_IC | C_STALL, 32'h0));
        #1;
        total_cnt++;
        if (nxt_c !== 32'h2) $display("FAIL next_seq_c16: got %h, want %h", nxt_c, 32'h2);
        else pass_cnt++;
        apply(mk_s(C_STALL, 32'h0));
        #1;
        total_cnt++;
        if (nxt_c !== 32'h4) $display("FAIL next_seq_c32: got %h, want %h", nxt_c, 32'h4);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stall_redirect();
        test_misalign();
        test_priority();
        test_halt();
        test_reset_in_halt();
        test_wrap();
        test_compressed();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, sets the width of PC, target and EPC.
REQ-002 Parameter RESET_VECTOR, default 0, is the PC loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 'h100, is the PC loaded on trap or misaligned redirect.
REQ-004 Parameter COMPRESSED, default 0; when 1, enables 2-byte increments and 2-byte alignment.
REQ-005 clk, input, 1: clock; all state updates on its rising edge.
REQ-006 reset, input, 1: asynchronous, active-high reset.
REQ-007 stall, input, 1: holds PC when high in RUN.
REQ-008 inst_compressed, input, 1: selects +2 increment when COMPRESSED=1; ignored otherwise.
REQ-009 redirect_valid, input, 1: requests a branch or jump to redirect_target.
REQ-010 redirect_target, input, XLEN: branch or jump target.
REQ-011 trap, input, 1: requests an exception entry.
REQ-012 mret, input, 1: requests a return to EPC.
REQ-013 halt_req, input, 1: requests a halt.
REQ-014 resume, input, 1: leaves HALT.
REQ-015 pc, output, XLEN: current PC, registered.
REQ-016 pc_next_seq, output, XLEN: pc+4, or pc+2 when COMPRESSED=1 and inst_compressed=1; combinational.
REQ-017 pc_valid, output, 1: high only in RUN.
REQ-018 epc, output, XLEN: registered exception PC.
REQ-019 misalign_err, output, 1: one-cycle registered pulse.
REQ-020 state, output, 2: encoding BOOT=0, RUN=1, HALT=2.

Function
REQ-021 FSM states SHALL be BOOT, RUN and HALT.
REQ-022 BOOT SHALL last exactly one cycle after reset deassertion, then go to RUN; pc holds RESET_VECTOR and pc_valid=0 during BOOT.
REQ-023 In RUN, the next-PC priority SHALL be: trap > mret > redirect_valid > halt_req > stall > sequential.
REQ-024 trap SHALL set epc<=pc and pc<=TRAP_VECTOR, and the FSM stays in RUN.
REQ-025 mret SHALL set pc<=epc and leave epc unchanged.
REQ-026 A redirect is misaligned when target[0]=1, or when COMPRESSED=0 and target[1]=1.
REQ-027 An aligned redirect SHALL set pc<=redirect_target.
REQ-028 A misaligned redirect SHALL set epc<=pc, pc<=TRAP_VECTOR and misalign_err=1 for the next cycle only.
REQ-029 halt_req SHALL hold pc and move to HALT; pc_valid=0 from the next cycle.
REQ-030 In HALT, pc SHALL hold and stall, redirect, mret and trap are ignored; resume moves to RUN next cycle with pc unchanged.
REQ-031 stall SHALL hold pc; sequential operation sets pc<=pc_next_seq.
REQ-032 Addition SHALL wrap modulo 2^XLEN, with no carry out (pc=all-ones-minus-3 -> 0).
REQ-033 pc_next_seq SHALL be computed from the current pc, independent of stall.
REQ-034 Inputs SHALL have no effect in BOOT.

Reset
REQ-035 On reset assertion, pc SHALL become RESET_VECTOR immediately (asynchronously).
REQ-036 On reset assertion, epc SHALL become 0, misalign_err 0, state BOOT and pc_valid 0.
REQ-037 Reset asserted mid-trap, mid-halt or mid-redirect SHALL discard the pending request; no state survives.

Structure
REQ-038 A shared package SHALL hold the state enum and the 2-byte and 4-byte increment constants.
REQ-039 One sub-module, pc_align_check (target in -> misaligned flag out, parametrised by COMPRESSED), SHALL be used.

Verification
REQ-040 Reset and boot: release reset with RESET_VECTOR='h80 -> pc='h80 and pc_valid=0 for 1 cycle, then pc='h84, 'h88 on successive cycles.
REQ-041 Stall and redirect: stall 3 cycles at pc='h10 -> pc stays 'h10; then redirect to 'h40 -> pc='h40 next cycle.
REQ-042 Misaligned redirect: COMPRESSED=0, pc='h20, target 'h42 -> pc='h100, epc='h20, misalign_err=1 for one cycle; then mret -> pc='h20.
REQ-043 Simultaneous events: trap, redirect and stall in the same cycle at pc='h30 -> pc='h100, epc='h30.
REQ-044 Compressed mode: COMPRESSED=1, inst_compressed=1 at pc='h2 -> pc='h4; a redirect to 'h6 is accepted; XLEN=32 with pc='hFFFFFFFC -> pc=0.
REQ-045 Halt and reset: halt at pc='h50, assert resume after 4 cycles -> pc='h50 then 'h54; assert reset while in HALT -> state=BOOT and pc=RESET_VECTOR immediately.
